// File: rtl/vga_sync_rx.sv
// VGA receive front end: measures hsync/vsync timing, locks onto a stable
// format and recovers a qualified pixel stream with x/y coordinates.
module vga_sync_rx #(
  parameter int H_START     = 144,
  parameter int H_VALID     = 640,
  parameter int V_START     = 35,
  parameter int V_VALID     = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_data,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_err,
  output logic [9:0]  h_total,
  output logic [9:0]  v_total
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [10:0] H_LO    = 11'(H_START);
  localparam logic [10:0] H_HI    = 11'(H_START + H_VALID);
  localparam logic [9:0]  H_LO10  = 10'(H_START);
  localparam logic [9:0]  V_LO    = 10'(V_START);
  localparam logic [9:0]  V_HI    = 10'(V_START + V_VALID);
  localparam logic [2:0]  LOCK_N  = 3'(LOCK_FRAMES);

  logic        hs_q_r, hs_q2_r, vs_q_r, vs_q2_r;
  logic [11:0] rgb_q_r;
  logic        hs_rise_s, vs_rise_s;
  logic [10:0] cnt_h_r;
  logic [9:0]  cnt_v_r;
  logic        h_seen_r;
  logic [10:0] line_ref_r;
  logic        first_line_r, line_err_r;
  logic [10:0] h_pos_s;
  logic [9:0]  v_pos_s;
  logic [9:0]  v_new_s;
  logic        timeout_s;
  logic        h_in_s, v_in_s;
  state_t      state_r, state_nx_s;
  logic [2:0]  good_cnt_r, good_cnt_nx_s, good_inc_s;
  logic [9:0]  v_ref_r, v_ref_nx_s;
  logic        err_s;

  assign hs_rise_s  = hs_q_r & ~hs_q2_r;
  assign vs_rise_s  = vs_q_r & ~vs_q2_r;
  assign h_pos_s    = hs_rise_s ? 11'd0 : cnt_h_r;
  assign v_pos_s    = vs_rise_s ? 10'd0 : cnt_v_r;
  assign v_new_s    = cnt_v_r + 10'd1;
  assign timeout_s  = (cnt_h_r == 11'h7FF) || (cnt_v_r == 10'h3FF);
  assign h_in_s     = (h_pos_s >= H_LO) && (h_pos_s < H_HI);
  assign v_in_s     = (v_pos_s >= V_LO) && (v_pos_s < V_HI);
  assign good_inc_s = good_cnt_r + 3'd1;

  // Input sampling and edge history
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q_r  <= 1'b0;
      hs_q2_r <= 1'b0;
      vs_q_r  <= 1'b0;
      vs_q2_r <= 1'b0;
      rgb_q_r <= 12'h000;
    end else begin
      hs_q_r  <= hsync;
      hs_q2_r <= hs_q_r;
      vs_q_r  <= vsync;
      vs_q2_r <= vs_q_r;
      rgb_q_r <= rgb;
    end
  end

  // Saturating horizontal/vertical position counters
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_h_r <= 11'd0;
      cnt_v_r <= 10'd0;
    end else begin
      if (hs_rise_s) begin
        cnt_h_r <= 11'd1;
        if (vs_rise_s) begin
          cnt_v_r <= 10'd0;
        end else if (cnt_v_r != 10'h3FF) begin
          cnt_v_r <= cnt_v_r + 10'd1;
        end
      end else if (cnt_h_r != 11'h7FF) begin
        cnt_h_r <= cnt_h_r + 11'd1;
      end
    end
  end

  // Line-length measurement and per-frame consistency check
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_seen_r     <= 1'b0;
      h_total      <= 10'd0;
      line_ref_r   <= 11'd0;
      first_line_r <= 1'b0;
      line_err_r   <= 1'b0;
    end else begin
      if (hs_rise_s) begin
        h_seen_r <= 1'b1;
        if (h_seen_r) begin
          h_total <= cnt_h_r[9:0];
        end
      end
      // The line closing on a vsync cycle belongs to the old frame and is dropped
      if (vs_rise_s) begin
        first_line_r <= 1'b1;
        line_err_r   <= 1'b0;
      end else if (hs_rise_s) begin
        if (first_line_r) begin
          line_ref_r   <= cnt_h_r;
          first_line_r <= 1'b0;
        end else if (cnt_h_r != line_ref_r) begin
          line_err_r <= 1'b1;
        end
      end
    end
  end

  // Lock FSM next-state logic; timeout outranks vsync evaluation
  always_comb begin
    state_nx_s    = state_r;
    good_cnt_nx_s = good_cnt_r;
    v_ref_nx_s    = v_ref_r;
    err_s         = 1'b0;
    if (timeout_s) begin
      state_nx_s = SEARCH;
      if (state_r != SEARCH) begin
        err_s = 1'b1;
      end else begin
        err_s = 1'b0;
      end
    end else if (vs_rise_s) begin
      case (state_r)
        SEARCH: begin
          state_nx_s    = CHECK;
          good_cnt_nx_s = 3'd0;
        end
        CHECK: begin
          v_ref_nx_s = v_new_s;
          if (!line_err_r && ((good_cnt_r == 3'd0) || (v_new_s == v_ref_r))) begin
            good_cnt_nx_s = good_inc_s;
            if (good_inc_s >= LOCK_N) begin
              state_nx_s = LOCKED;
            end else begin
              state_nx_s = CHECK;
            end
          end else begin
            good_cnt_nx_s = line_err_r ? 3'd0 : 3'd1;
            err_s         = 1'b1;
          end
        end
        LOCKED: begin
          if (line_err_r || (v_new_s != v_ref_r)) begin
            state_nx_s    = CHECK;
            good_cnt_nx_s = 3'd0;
            err_s         = 1'b1;
          end else begin
            state_nx_s = LOCKED;
          end
        end
        default: begin
          state_nx_s    = SEARCH;
          good_cnt_nx_s = 3'd0;
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // Lock FSM state and frame bookkeeping
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= SEARCH;
      good_cnt_r  <= 3'd0;
      v_ref_r     <= 10'd0;
      v_total     <= 10'd0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      good_cnt_r  <= good_cnt_nx_s;
      v_ref_r     <= v_ref_nx_s;
      locked      <= (state_r == LOCKED);
      sync_err    <= err_s;
      frame_start <= vs_rise_s;
      if (vs_rise_s && (state_r != SEARCH)) begin
        v_total <= v_new_s;
      end
    end
  end

  // Qualified pixel output
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      pix_x     <= 10'h3FF;
      pix_y     <= 10'h3FF;
      pix_data  <= 12'h000;
    end else if (locked && h_in_s && v_in_s) begin
      pix_valid <= 1'b1;
      pix_x     <= h_pos_s[9:0] - H_LO10;
      pix_y     <= v_pos_s - V_LO;
      pix_data  <= rgb_q_r;
    end else begin
      pix_valid <= 1'b0;
      pix_x     <= 10'h3FF;
      pix_y     <= 10'h3FF;
      pix_data  <= 12'h000;
    end
  end

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx using a reduced 40x12 raster so that
// many frames fit in a short run; all timing windows scale with parameters.
module tb_vga_sync_rx;
  localparam int HS = 10;
  localparam int HV = 20;
  localparam int VS = 3;
  localparam int VV = 6;
  localparam int HT = 40;
  localparam int VT = 12;

  logic        vga_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        hsync   = 1'b0;
  logic        vsync   = 1'b0;
  logic [11:0] rgb     = 12'h000;
  logic [9:0]  pix_x, pix_y, h_total, v_total;
  logic [11:0] pix_data;
  logic        pix_valid, frame_start, locked, sync_err;

  vga_sync_rx #(
    .H_START(HS), .H_VALID(HV), .V_START(VS), .V_VALID(VV), .LOCK_FRAMES(2)
  ) dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data), .pix_valid(pix_valid),
    .frame_start(frame_start), .locked(locked), .sync_err(sync_err),
    .h_total(h_total), .v_total(v_total)
  );

  always #5 vga_clk = ~vga_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fs_count = 0, err_count = 0, valid_count = 0;
  int pix_bad = 0, idle_bad = 0, last_seen = 0;
  int lock_rise_fs = 0, lock_rise_cyc = 0, lock_fs_cyc = 0, fs_cyc = 0;
  int first_valid_cyc = 0, drv_first_cyc = 0;
  logic [11:0] first_valid_data = 12'h000;
  logic [11:0] exp_d;
  logic [9:0]  exp_x = 10'd0, exp_y = 10'd0;
  logic        locked_prev = 1'b0;

  always @(posedge vga_clk) cyc <= cyc + 1;

  // Output monitor with an independent raster-order pixel model
  always @(negedge vga_clk) begin
    if (!rst_n) begin
      exp_x = 10'd0;
      exp_y = 10'd0;
    end else begin
      if (frame_start) begin
        fs_count++;
        fs_cyc = cyc;
        exp_x = 10'd0;
        exp_y = 10'd0;
      end
      if (locked && !locked_prev) begin
        lock_rise_cyc = cyc;
        lock_rise_fs  = fs_count;
        lock_fs_cyc   = fs_cyc;
      end
      if (sync_err) err_count++;
      if (pix_valid) begin
        valid_count++;
        exp_d = {exp_x[3:0], exp_y[3:0], 4'hA};
        if (pix_x !== exp_x || pix_y !== exp_y || pix_data !== exp_d) pix_bad++;
        if (exp_x == 10'd0 && exp_y == 10'd0) begin
          first_valid_cyc  = cyc;
          first_valid_data = pix_data;
        end
        if (exp_x == 10'(HV - 1) && exp_y == 10'(VV - 1)) last_seen++;
        if (exp_x == 10'(HV - 1)) begin
          exp_x = 10'd0;
          exp_y = exp_y + 10'd1;
        end else begin
          exp_x = exp_x + 10'd1;
        end
      end else if (pix_x !== 10'h3FF || pix_y !== 10'h3FF || pix_data !== 12'h000) begin
        idle_bad++;
      end
    end
    locked_prev = locked;
  end

  task automatic send_frame(input int vt, input int short_line, input int cut);
    int n = 0;
    int len;
    logic [9:0] px, py;
    for (int l = 0; l < vt; l++) begin
      len = (l == short_line) ? HT - 1 : HT;
      for (int c = 0; c < len; c++) begin
        if (cut > 0 && n == cut) return;
        @(negedge vga_clk);
        hsync = (c < 4);
        vsync = (l < 1);
        if (c >= HS && c < HS + HV && l >= VS && l < VS + VV) begin
          px  = 10'(c - HS);
          py  = 10'(l - VS);
          rgb = {px[3:0], py[3:0], 4'hA};
        end else begin
          rgb = 12'h000;
        end
        if (c == HS && l == VS) drv_first_cyc = cyc;
        n++;
      end
    end
  endtask

  task automatic test_reset;
    repeat (4) @(negedge vga_clk);
    total++; if (pix_x !== 10'h3FF) begin bad++; $display("FAIL rst_pix_x got=%h want=3ff", pix_x); end
    total++; if (pix_y !== 10'h3FF) begin bad++; $display("FAIL rst_pix_y got=%h want=3ff", pix_y); end
    total++; if (pix_data !== 12'h000) begin bad++; $display("FAIL rst_pix_data got=%h want=000", pix_data); end
    total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL rst_pix_valid got=%b want=0", pix_valid); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL rst_frame_start got=%b want=0", frame_start); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked got=%b want=0", locked); end
    total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL rst_sync_err got=%b want=0", sync_err); end
    total++; if (h_total !== 10'd0) begin bad++; $display("FAIL rst_h_total got=%0d want=0", h_total); end
    total++; if (v_total !== 10'd0) begin bad++; $display("FAIL rst_v_total got=%0d want=0", v_total); end
    rst_n = 1'b1;
    repeat (3) @(negedge vga_clk);
  endtask

  task automatic test_lock;
    int v0;
    send_frame(VT, -1, 0);
    send_frame(VT, -1, 0);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_early got=%b want=0", locked); end
    total++; if (fs_count != 2) begin bad++; $display("FAIL lock_fs_count got=%0d want=2", fs_count); end
    v0 = valid_count;
    send_frame(VT, -1, 0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_locked got=%b want=1", locked); end
    total++; if (lock_rise_fs != 3) begin bad++; $display("FAIL lock_after_fs got=%0d want=3", lock_rise_fs); end
    total++; if (lock_rise_cyc - lock_fs_cyc != 1) begin bad++; $display("FAIL lock_delay got=%0d want=1", lock_rise_cyc - lock_fs_cyc); end
    total++; if (h_total !== 10'(HT)) begin bad++; $display("FAIL lock_h_total got=%0d want=%0d", h_total, HT); end
    total++; if (v_total !== 10'(VT)) begin bad++; $display("FAIL lock_v_total got=%0d want=%0d", v_total, VT); end
    total++; if (valid_count - v0 != HV * VV) begin bad++; $display("FAIL lock_valid_count got=%0d want=%0d", valid_count - v0, HV * VV); end
    total++; if (first_valid_cyc - drv_first_cyc != 2) begin bad++; $display("FAIL first_pix_latency got=%0d want=2", first_valid_cyc - drv_first_cyc); end
    total++; if (first_valid_data !== 12'h00A) begin bad++; $display("FAIL first_pix_data got=%h want=00a", first_valid_data); end
    total++; if (last_seen != 1) begin bad++; $display("FAIL last_pix_seen got=%0d want=1", last_seen); end
    total++; if (err_count != 0) begin bad++; $display("FAIL lock_no_err got=%0d want=0", err_count); end
  endtask

  task automatic test_short_line;
    int e0, v0;
    e0 = err_count;
    v0 = valid_count;
    send_frame(VT, 5, 0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL sl_still_locked got=%b want=1", locked); end
    total++; if (valid_count - v0 != HV * VV) begin bad++; $display("FAIL sl_valid got=%0d want=%0d", valid_count - v0, HV * VV); end
    v0 = valid_count;
    send_frame(VT, -1, 0);
    total++; if (err_count - e0 != 1) begin bad++; $display("FAIL sl_err got=%0d want=1", err_count - e0); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL sl_unlocked got=%b want=0", locked); end
    total++; if (valid_count != v0) begin bad++; $display("FAIL sl_no_valid got=%0d want=0", valid_count - v0); end
    send_frame(VT, -1, 0);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL sl_relock_early got=%b want=0", locked); end
    send_frame(VT, -1, 0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL sl_relocked got=%b want=1", locked); end
    total++; if (lock_rise_fs != 7) begin bad++; $display("FAIL sl_relock_fs got=%0d want=7", lock_rise_fs); end
  endtask

  task automatic test_short_frame;
    int e0;
    e0 = err_count;
    send_frame(VT - 1, -1, 0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL sf_still_locked got=%b want=1", locked); end
    send_frame(VT, -1, 0);
    total++; if (err_count - e0 != 1) begin bad++; $display("FAIL sf_err got=%0d want=1", err_count - e0); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL sf_unlocked got=%b want=0", locked); end
    total++; if (v_total !== 10'(VT - 1)) begin bad++; $display("FAIL sf_v_total got=%0d want=%0d", v_total, VT - 1); end
    send_frame(VT, -1, 0);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL sf_relock_early got=%b want=0", locked); end
    total++; if (v_total !== 10'(VT)) begin bad++; $display("FAIL sf_v_total2 got=%0d want=%0d", v_total, VT); end
    send_frame(VT, -1, 0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL sf_relocked got=%b want=1", locked); end
    total++; if (lock_rise_fs != 11) begin bad++; $display("FAIL sf_relock_fs got=%0d want=11", lock_rise_fs); end
  endtask

  task automatic test_timeout;
    int e0, v0;
    e0 = err_count;
    v0 = valid_count;
    for (int i = 0; i < 2100; i++) begin
      @(negedge vga_clk);
      hsync = 1'b0;
      vsync = 1'b0;
      rgb   = 12'h000;
    end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL to_unlocked got=%b want=0", locked); end
    total++; if (err_count - e0 != 1) begin bad++; $display("FAIL to_err_once got=%0d want=1", err_count - e0); end
    total++; if (valid_count != v0) begin bad++; $display("FAIL to_no_valid got=%0d want=0", valid_count - v0); end
    // first vsync lands while cnt_h is still saturated, so it is swallowed
    for (int f = 0; f < 3; f++) send_frame(VT, -1, 0);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL to_relock_early got=%b want=0", locked); end
    send_frame(VT, -1, 0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL to_relocked got=%b want=1", locked); end
    total++; if (lock_rise_fs != 15) begin bad++; $display("FAIL to_relock_fs got=%0d want=15", lock_rise_fs); end
    total++; if (err_count - e0 != 1) begin bad++; $display("FAIL to_err_total got=%0d want=1", err_count - e0); end
  endtask

  task automatic test_reset_mid;
    int fs_snap;
    send_frame(VT, -1, 4 * HT + 15);
    @(negedge vga_clk);
    total++; if (pix_valid !== 1'b1) begin bad++; $display("FAIL rm_active got=%b want=1", pix_valid); end
    rst_n = 1'b0;
    #1;
    total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL rm_pix_valid got=%b want=0", pix_valid); end
    total++; if (pix_x !== 10'h3FF || pix_y !== 10'h3FF) begin bad++; $display("FAIL rm_pix_xy got=%h/%h want=3ff/3ff", pix_x, pix_y); end
    total++; if (pix_data !== 12'h000) begin bad++; $display("FAIL rm_pix_data got=%h want=000", pix_data); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL rm_locked got=%b want=0", locked); end
    total++; if (h_total !== 10'd0 || v_total !== 10'd0) begin bad++; $display("FAIL rm_totals got=%0d/%0d want=0/0", h_total, v_total); end
    fs_snap = fs_count;
    repeat (3) @(negedge vga_clk);
    rst_n = 1'b1;
    send_frame(VT, -1, 0);
    send_frame(VT, -1, 0);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL rm_relock_early got=%b want=0", locked); end
    send_frame(VT, -1, 0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL rm_relocked got=%b want=1", locked); end
    total++; if (lock_rise_fs != fs_snap + 3) begin bad++; $display("FAIL rm_relock_fs got=%0d want=%0d", lock_rise_fs, fs_snap + 3); end
    total++; if (h_total !== 10'(HT)) begin bad++; $display("FAIL rm_h_total got=%0d want=%0d", h_total, HT); end
  endtask

  task automatic test_stream_integrity;
    total++; if (pix_bad != 0) begin bad++; $display("FAIL pix_stream got=%0d bad pixels want=0", pix_bad); end
    total++; if (idle_bad != 0) begin bad++; $display("FAIL idle_values got=%0d bad cycles want=0", idle_bad); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_short_line();
    test_short_frame();
    test_timeout();
    test_reset_mid();
    test_stream_integrity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
- Receive end of the 640x480@60 VGA link: samples hsync, vsync and 12-bit rgb on the pixel clock.
- Measures line and frame timing and locks onto a stable format.
- Recovers pixel coordinates and emits a qualified pixel stream (pix_x, pix_y, pix_data, pix_valid) for a frame-capture or overlay block.
- Sync pulses are active-high, rising edge = start of sync. hsync and vsync rise on the same clock at frame start.

Parameters:
- H_START, 144, first active column counted from hsync rising edge (sync 96 + back 40 + left border 8).
- H_VALID, 640, active pixels per line.
- V_START, 35, first active line counted from vsync rising edge (2 + 25 + 8).
- V_VALID, 480, active lines per frame.
- LOCK_FRAMES, 2, consecutive good frames required to assert locked (1..7).

Ports:
- vga_clk  in  1  pixel clock; same clock as the transmitter.
- rst_n  in  1  asynchronous active-low reset.
- hsync  in  1  horizontal sync, active-high.
- vsync  in  1  vertical sync, active-high.
- rgb  in  12  pixel data, 4:4:4.
- pix_x  out  10  active column 0..639 when pix_valid, else 10'h3FF.
- pix_y  out  10  active line 0..479 when pix_valid, else 10'h3FF.
- pix_data  out  12  captured rgb when pix_valid, else 0.
- pix_valid  out  1  qualified active pixel.
- frame_start  out  1  one-cycle pulse on each detected vsync rise.
- locked  out  1  format stable.
- sync_err  out  1  one-cycle pulse when a frame check fails or timeout fires while CHECK/LOCKED.
- h_total  out  10  last measured line length in clocks.
- v_total  out  10  last measured frame length in lines.

Behaviour:
- All outputs are registered. Reset values: pix_x = pix_y = 10'h3FF, pix_data = 0, pix_valid = 0, frame_start = 0, locked = 0, sync_err = 0, h_total = 0, v_total = 0. FSM resets to SEARCH.
- Input stage: hsync, vsync and rgb are registered once (hs_q, vs_q, rgb_q); hs_q2 and vs_q2 hold the previous samples.
  - hs_rise = hs_q & ~hs_q2; vs_rise = vs_q & ~vs_q2.
- Horizontal counter: cnt_h (11 bits) loads 1 on hs_rise, otherwise increments, saturating at 2047.
  - h_pos = hs_rise ? 0 : cnt_h. This equals the transmitter's column for the rgb_q sample.
- Line length: on hs_rise, if at least one earlier hs_rise has been seen, h_total <= cnt_h[9:0] (800 for a conforming stream).
  - The first line after each vs_rise sets line_ref.
  - Any later line in the same frame whose length differs from line_ref sets line_err; line_err clears on vs_rise.
- Vertical counter: cnt_v (10 bits) advances on hs_rise only: 0 if vs_rise on the same cycle, else +1, saturating at 1023.
  - v_pos = cnt_v, or 0 on a vs_rise cycle.
  - On vs_rise, v_total <= cnt_v + 1 (525 for a conforming stream). Not updated on the first vs_rise after SEARCH.
- Pixel output, 2-cycle latency from the rgb pin to pix_data:
  - pix_valid <= locked & (H_START <= h_pos < H_START+H_VALID) & (V_START <= v_pos < V_START+V_VALID).
  - When valid: pix_x <= h_pos - H_START, pix_y <= v_pos - V_START, pix_data <= rgb_q.
  - When not valid: pix_x = pix_y = 10'h3FF, pix_data = 0.
- frame_start <= vs_rise, in every state.
- Lock FSM:
  - SEARCH: on vs_rise -> CHECK, good_cnt = 0.
  - CHECK, on vs_rise, frame is good if line_err = 0 and (good_cnt = 0 or new v_total = stored v_ref).
    - Good: good_cnt+1 and v_ref stored. Reaching LOCK_FRAMES -> LOCKED, locked = 1 from the next cycle.
    - Bad: good_cnt = 1 if line_err = 0, else 0; v_ref <= new v_total; sync_err pulse.
  - LOCKED, on vs_rise: a bad frame -> CHECK, locked = 0 the next cycle, sync_err pulse, good_cnt = 0.
  - Timeout in any state: cnt_h reaching 2047 (no hsync) or cnt_v reaching 1023 (no vsync) -> SEARCH.
    - locked = 0; counters keep their values; sync_err pulses once if leaving CHECK or LOCKED.
- Simultaneous events:
  - vs_rise is evaluated with line_err as it stood before that cycle's line check.
  - A timeout on the same cycle as vs_rise takes priority.
- Reset mid-frame: immediate return to reset values; re-lock requires LOCK_FRAMES good frames after the first vs_rise.

Test Plan:
- Conforming 800x525 stream with pixel value = {x[3:0], y[3:0], 4'hA} -> locked rises the cycle after the 3rd frame_start; h_total = 800, v_total = 525.
- After lock, trace the first pixel: rgb driven at transmitter column 144, line 35 -> two clocks later pix_valid = 1, pix_x = 0, pix_y = 0, pix_data = 12'h00A. Last pixel -> pix_x = 639, pix_y = 479. Exactly 307200 valid pixels per frame.
- While locked, shorten one line to 799 clocks -> at the next frame_start sync_err pulses and locked drops; re-locked two frames later.
- While locked, send one frame of 524 lines -> sync_err and unlock at that frame's end vsync; relock after 2 clean frames.
- Hold hsync low for 2100 clocks -> SEARCH, locked = 0, one sync_err pulse, pix_valid stays 0.
- Assert rst_n low mid-line on a locked stream -> all outputs at reset values immediately; locked returns only after 3 frame_starts.
